// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder top and its storage array.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int OFFSET_W = 2;
  localparam int STRB_W   = 4;

  // Wait counter must hold WAIT_CYCLES-1 and never collapse to zero width
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous per-byte-lane write, asynchronous word read.
// Contents are deliberately untouched by reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 64,
  parameter string INIT_FILE   = "",
  localparam int   AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [31:0]       wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-lane write merge
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we_i && wstrb_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory slave with programmable wait states, byte strobes
// and error reporting for misaligned or out-of-range accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int                CNT_W       = cnt_width(WAIT_CYCLES);
  localparam int                AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]       LIMIT_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;

  logic                cur_we_s;
  logic [31:0]         cur_addr_s;
  logic [31:0]         cur_wdata_s;
  logic [STRB_W-1:0]   cur_wstrb_s;
  logic [31:0]         offset_s;
  logic                accept_s;
  logic                commit_s;
  logic                mem_we_s;
  logic [31:0]         mem_rdata_s;
  logic [31:0]         rsp_rdata_d;
  logic                rsp_err_d;

  // With zero wait states the commit edge is the acceptance edge, so the live
  // request fields are used instead of the not-yet-latched copies.
  always_comb begin
    accept_s    = (state_q == IDLE) && req_valid && req_ready_q;
    cur_we_s    = (state_q == IDLE) ? req_we    : we_q;
    cur_addr_s  = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata_s = (state_q == IDLE) ? req_wdata : wdata_q;
    cur_wstrb_s = (state_q == IDLE) ? req_wstrb : wstrb_q;
    offset_s    = cur_addr_s - BASE_ADDR;
    rsp_err_d   = (|cur_addr_s[OFFSET_W-1:0]) || (cur_addr_s < BASE_ADDR) ||
                  (offset_s >= LIMIT_BYTES);
    commit_s    = ((state_q == WAIT) && (cnt_q == '0)) ||
                  (accept_s && (WAIT_CYCLES == 0));
    mem_we_s    = commit_s && cur_we_s && !rsp_err_d;
    rsp_rdata_d = (cur_we_s || rsp_err_d) ? 32'h0000_0000 : mem_rdata_s;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (offset_s[AW+1:OFFSET_W]),
    .wstrb_i (cur_wstrb_s),
    .wdata_i (cur_wdata_s),
    .raddr_i (offset_s[AW+1:OFFSET_W]),
    .rdata_o (mem_rdata_s)
  );

  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      wstrb_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'h0000_0000;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT with two wait states, one with none.
module tb_dmem_responder;

  logic clk;
  logic reset;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_wstrb;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wstrb;

  int checks;
  int fails;

  dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transaction with rsp_ready held high; lat counts edges from
  // the acceptance edge (inclusive) until rsp_valid is first seen.
  task automatic txn(input bit sel, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rd, output logic er,
                     output int lat, output int stall);
    @(negedge clk);
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_wstrb = strb;
      b_rsp_ready = 1'b1;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_wstrb = strb;
      a_rsp_ready = 1'b1;
    end
    stall = 0;
    while (!(sel ? b_req_ready : a_req_ready) && stall < 20) begin
      @(negedge clk);
      stall++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (sel) b_req_valid = 1'b0; else a_req_valid = 1'b0;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = sel ? b_rsp_rdata : a_rsp_rdata;
    er = sel ? b_rsp_err : a_rsp_err;
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (a_req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
    if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
    if (a_rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
    if (a_rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
    checks += 2;
    if (b_req_ready !== 1'b1) begin fails++; $display("FAIL reset_b_req_ready got=%b exp=1", b_req_ready); end
    if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_b_rsp_valid got=%b exp=0", b_rsp_valid); end
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat; int st;
    txn(1'b0, 1'b1, 32'h60, 32'h0000_0019, 4'b1111, rd, er, lat, st);
    checks += 3;
    if (lat !== 3) begin fails++; $display("FAIL wr60_latency got=%0d exp=3", lat); end
    if (er !== 1'b0) begin fails++; $display("FAIL wr60_err got=%b exp=0", er); end
    if (rd !== 32'h0) begin fails++; $display("FAIL wr60_rdata got=%h exp=0", rd); end
    txn(1'b0, 1'b0, 32'h60, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 3;
    if (lat !== 3) begin fails++; $display("FAIL rd60_latency got=%0d exp=3", lat); end
    if (er !== 1'b0) begin fails++; $display("FAIL rd60_err got=%b exp=0", er); end
    if (rd !== 32'h0000_0019) begin fails++; $display("FAIL rd60_rdata got=%h exp=00000019", rd); end
  endtask

  task automatic test_strobe;
    logic [31:0] rd; logic er; int lat; int st;
    txn(1'b0, 1'b1, 32'h64, 32'hAABB_CCDD, 4'b1111, rd, er, lat, st);
    txn(1'b0, 1'b1, 32'h64, 32'h1122_3344, 4'b0101, rd, er, lat, st);
    txn(1'b0, 1'b0, 32'h64, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 2;
    if (rd !== 32'hAA22_CC44) begin fails++; $display("FAIL strobe_merge got=%h exp=aa22cc44", rd); end
    if (er !== 1'b0) begin fails++; $display("FAIL strobe_err got=%b exp=0", er); end
    // zero strobes: legal no-op
    txn(1'b0, 1'b1, 32'h60, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, st);
    checks += 1;
    if (er !== 1'b0) begin fails++; $display("FAIL zero_strb_err got=%b exp=0", er); end
    txn(1'b0, 1'b0, 32'h60, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 1;
    if (rd !== 32'h0000_0019) begin fails++; $display("FAIL zero_strb_data got=%h exp=00000019", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat; int st;
    txn(1'b0, 1'b1, 32'h00, 32'h0BAD_F00D, 4'b1111, rd, er, lat, st);
    txn(1'b0, 1'b0, 32'h62, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 2;
    if (er !== 1'b1) begin fails++; $display("FAIL misalign_err got=%b exp=1", er); end
    if (rd !== 32'h0) begin fails++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
    txn(1'b0, 1'b0, 32'h100, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 2;
    if (er !== 1'b1) begin fails++; $display("FAIL range_err got=%b exp=1", er); end
    if (rd !== 32'h0) begin fails++; $display("FAIL range_rdata got=%h exp=0", rd); end
    txn(1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'b1111, rd, er, lat, st);
    checks += 1;
    if (er !== 1'b1) begin fails++; $display("FAIL range_wr_err got=%b exp=1", er); end
    txn(1'b0, 1'b1, 32'h61, 32'hFFFF_FFFF, 4'b1111, rd, er, lat, st);
    txn(1'b0, 1'b0, 32'h00, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 1;
    if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL range_wr_word0 got=%h exp=0badf00d", rd); end
    txn(1'b0, 1'b0, 32'h60, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 1;
    if (rd !== 32'h0000_0019) begin fails++; $display("FAIL range_wr_word60 got=%h exp=00000019", rd); end
    txn(1'b0, 1'b0, 32'h64, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 1;
    if (rd !== 32'hAA22_CC44) begin fails++; $display("FAIL range_wr_word64 got=%h exp=aa22cc44", rd); end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h60; a_req_wstrb = 4'b0000;
    a_rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (a_rsp_valid !== 1'b1) begin fails++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, a_rsp_valid); end
      if (a_rsp_rdata !== 32'h0000_0019) begin fails++; $display("FAIL hold_rdata cyc=%0d got=%h exp=00000019", i, a_rsp_rdata); end
      if (a_req_ready !== 1'b0) begin fails++; $display("FAIL hold_req_ready cyc=%0d got=%b exp=0", i, a_req_ready); end
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (a_req_ready !== 1'b1) begin fails++; $display("FAIL release_req_ready got=%b exp=1", a_req_ready); end
    if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL release_rsp_valid got=%b exp=0", a_rsp_valid); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat; int st;
    txn(1'b0, 1'b1, 32'h68, 32'h1234_5678, 4'b1111, rd, er, lat, st);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h68; a_req_wdata = 32'hDEAD_BEEF; a_req_wstrb = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks += 2;
    if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL midreset_rsp_valid got=%b exp=0", a_rsp_valid); end
    if (a_req_ready !== 1'b1) begin fails++; $display("FAIL midreset_req_ready got=%b exp=1", a_req_ready); end
    txn(1'b0, 1'b0, 32'h68, 32'h0, 4'b0000, rd, er, lat, st);
    checks += 1;
    if (rd !== 32'h1234_5678) begin fails++; $display("FAIL midreset_data got=%h exp=12345678", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat; int st;
    logic [31:0] vals [3];
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222; vals[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, 1'b1, 32'(4 * i), vals[i], 4'b1111, rd, er, lat, st);
      checks += 2;
      if (lat !== 1) begin fails++; $display("FAIL b2b_wr_latency idx=%0d got=%0d exp=1", i, lat); end
      if (st !== 0) begin fails++; $display("FAIL b2b_wr_bubble idx=%0d got=%0d exp=0", i, st); end
    end
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, 1'b0, 32'(4 * i), 32'h0, 4'b0000, rd, er, lat, st);
      checks += 3;
      if (lat !== 1) begin fails++; $display("FAIL b2b_rd_latency idx=%0d got=%0d exp=1", i, lat); end
      if (rd !== vals[i]) begin fails++; $display("FAIL b2b_rd_data idx=%0d got=%h exp=%h", i, rd, vals[i]); end
      if (er !== 1'b0) begin fails++; $display("FAIL b2b_rd_err idx=%0d got=%b exp=0", i, er); end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_req_wstrb = 4'b0000;
    a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_req_wstrb = 4'b0000;
    b_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_strobe();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
